// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: tracks the input, binary-searches
// it against an off-block DAC using a synchronized comparator bit, and
// reports the code with start/busy/done/valid handshaking and abort.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  localparam int SampW = $clog2(SAMPLE_CYCLES + 1);
  localparam int SettW = $clog2(SETTLE_CYCLES + 1);
  localparam int IdxW  = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StSample, StConv, StDone} state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               cmp_s;
  logic [SampW-1:0]   samp_cnt_q;
  logic [SettW-1:0]   sett_cnt_q;
  logic [IdxW-1:0]    idx_q;
  logic [WIDTH-1:0]   code_q;
  logic [WIDTH-1:0]   result_q;
  logic               valid_q;
  logic               samp_last;
  logic               win_end;
  logic               conv_last;
  logic [WIDTH-1:0]   trial_bit;
  logic [WIDTH-1:0]   code_next;

  assign cmp_s     = sync_q[SYNC_STAGES-1];
  assign samp_last = (state_q == StSample) && (samp_cnt_q == SampW'(SAMPLE_CYCLES - 1));
  assign win_end   = (state_q == StConv) && (sett_cnt_q == SettW'(SETTLE_CYCLES - 1));
  assign conv_last = win_end && (idx_q == '0);

  // Trial decision: keep or drop the current bit, then tentatively set the next lower one.
  always_comb begin
    trial_bit = WIDTH'(1) << idx_q;
    code_next = (code_q & ~trial_bit) | (cmp_s ? trial_bit : '0) | (trial_bit >> 1);
  end

  // Comparator synchronizer; the raw cmp_in is never used elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort only matters while a conversion is in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSample;
      StSample: begin
        if (abort) state_d = StIdle;
        else if (samp_last) state_d = StConv;
      end
      StConv: begin
        if (abort) state_d = StIdle;
        else if (conv_last) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath: counters, trial code, result and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q <= '0;
      sett_cnt_q <= '0;
      idx_q      <= '0;
      code_q     <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          code_q <= '0;
          if (start) begin
            samp_cnt_q <= '0;
            valid_q    <= 1'b0;
          end
        end
        StSample: begin
          if (abort) begin
            code_q <= '0;
          end else if (samp_last) begin
            idx_q      <= IdxW'(WIDTH - 1);
            code_q     <= {1'b1, {(WIDTH-1){1'b0}}};
            sett_cnt_q <= '0;
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end
        StConv: begin
          if (abort) begin
            code_q <= '0;
          end else if (win_end) begin
            sett_cnt_q <= '0;
            code_q     <= code_next;
            if (idx_q == '0) begin
              result_q <= code_next;
              valid_q  <= 1'b1;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end else begin
            sett_cnt_q <= sett_cnt_q + 1'b1;
          end
        end
        // DONE shows the final code for one cycle; IDLE drives 0 again.
        StDone:  code_q <= '0;
        default: code_q <= '0;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    sample = (state_q == StSample);
    busy   = (state_q == StSample) || (state_q == StConv);
    done   = (state_q == StDone);
  end

  assign dac_code = code_q;
  assign result   = result_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator model, directed handshake/abort/reset
// steps followed by random input levels.
module tb_sar_adc_ctrl;

  localparam int W = 8;
  localparam int S = 2;
  localparam int T = 4;
  localparam int D = S + W * T;  // edges from start acceptance to DONE

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         cmp_in;
  logic         sample;
  logic [W-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         valid;

  logic [W-1:0] vin = '0;
  logic         glitch = 1'b0;
  logic [W-1:0] prev_result = '0;
  int           checks = 0;
  int           errors = 0;

  // Ideal comparator, optionally inverted for a one-cycle glitch.
  assign cmp_in = (vin >= dac_code) ^ glitch;

  always #5 clk = ~clk;

  sar_adc_ctrl #(
    .WIDTH(W),
    .SAMPLE_CYCLES(S),
    .SETTLE_CYCLES(T),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .cmp_in(cmp_in),
    .sample(sample),
    .dac_code(dac_code),
    .busy(busy),
    .done(done),
    .result(result),
    .valid(valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trial level while bit b is under test: bits above b already equal vin, bit b set.
  function automatic logic [W-1:0] trial(input logic [W-1:0] v, input int b);
    int t;
    t = ((int'(v) >> (b + 1)) << (b + 1)) | (1 << b);
    return W'(t);
  endfunction

  // One conversion from start acceptance. abort_at/pulse_at/glitch_at are
  // edge offsets from the accepting edge (-1 = unused).
  task automatic run(input string tag, input logic [W-1:0] v, input int abort_at,
                     input int pulse_at, input int glitch_at, input bit hold);
    int           busy_cnt;
    bit           ab;
    logic [3:0]   ec;
    logic [W-1:0] ed;
    logic [W-1:0] er;
    vin = v;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    busy_cnt = 0;
    ab = 1'b0;
    for (int n = 0; n <= D + 1; n++) begin
      if (abort_at >= 0 && n == abort_at) ab = 1'b1;
      er = prev_result;
      if (ab) begin
        ec = 4'b0000; ed = '0;
      end else if (n < S) begin
        ec = 4'b1100; ed = '0;
      end else if (n < D) begin
        ec = 4'b0100; ed = trial(v, W - 1 - (n - S) / T);
      end else if (n == D) begin
        ec = 4'b0011; ed = v; er = v;
      end else begin
        ec = 4'b0001; ed = '0; er = v;
      end
      check($sformatf("%s n%0d ctrl{smp,bsy,dn,vld}", tag, n),
            {28'd0, sample, busy, done, valid}, {28'd0, ec});
      check($sformatf("%s n%0d dac_code", tag, n), {24'd0, dac_code}, {24'd0, ed});
      check($sformatf("%s n%0d result", tag, n), {24'd0, result}, {24'd0, er});
      if (busy) busy_cnt++;
      if (!ab && n == D) prev_result = v;
      abort  = (n + 1 == abort_at);
      start  = hold || (n + 1 == pulse_at);
      glitch = (glitch_at >= 0 && n == glitch_at);
      if (ab && n >= abort_at + 3) break;
      if (n < D + 1) tick();
    end
    abort = 1'b0;
    glitch = 1'b0;
    if (!hold) start = 1'b0;
    if (!ab) check($sformatf("%s busy cycles", tag), busy_cnt, D);
  endtask

  initial begin
    logic [W-1:0] v;
    int           g;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset ctrl", {28'd0, sample, busy, done, valid}, 32'd0);
    check("reset dac", {24'd0, dac_code}, 32'd0);
    check("reset result", {24'd0, result}, 32'd0);
    tick();

    // Basic conversion and endpoints.
    run("basic_a5", 8'hA5, -1, -1, -1, 1'b0);
    tick();
    run("vin_00", 8'h00, -1, -1, -1, 1'b0);
    tick();
    run("vin_ff", 8'hFF, -1, -1, -1, 1'b0);
    tick();

    // Second start mid-conversion is ignored.
    run("restart_ignored", 8'h5A, -1, 10, -1, 1'b0);
    tick();

    // Held start: back-to-back with one IDLE cycle; second clears valid.
    run("hold_first", 8'h33, -1, -1, -1, 1'b1);
    run("hold_second", 8'hC7, -1, -1, -1, 1'b0);
    tick();

    // Abort with a prior result of 0xA5.
    run("pre_abort", 8'hA5, -1, -1, -1, 1'b0);
    tick();
    run("abort_k12", 8'h4E, 12, -1, -1, 1'b0);
    run("abort_sample", 8'h91, 1, -1, -1, 1'b0);
    tick();

    // Abort together with start in IDLE: start wins.
    abort = 1'b1;
    run("abort_with_start", 8'h6B, -1, -1, -1, 1'b0);
    tick();

    // Comparator glitch early in the MSB window and in a later window.
    run("glitch_w0", 8'hA5, -1, -1, S, 1'b0);
    tick();
    run("glitch_w3", 8'h2C, -1, -1, S + 3 * T, 1'b0);
    tick();

    // Reset in the bit-5 window.
    vin = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_result = '0;
    check("midreset ctrl", {28'd0, sample, busy, done, valid}, 32'd0);
    check("midreset dac", {24'd0, dac_code}, 32'd0);
    check("midreset result", {24'd0, result}, 32'd0);
    tick();
    check("midreset idle busy", {31'd0, busy}, 32'd0);
    run("after_reset_3c", 8'h3C, -1, -1, -1, 1'b0);
    tick();

    // Random levels, some with a window-start glitch.
    for (int i = 0; i < 16; i++) begin
      v = W'($urandom_range(0, 255));
      g = ($urandom_range(0, 1) == 1) ? S + T * int'($urandom_range(0, W - 1)) : -1;
      run($sformatf("rand%0d", i), v, -1, -1, g, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Digital successive-approximation controller that reads back the analog front end (diff amp / OTA output) into a digital code.
- Drives the trial code to an off-block R-2R / cap DAC and a track/hold enable, reads a single comparator bit, and binary-searches the input.
- Sits between the analog macros and the uo_out/uio pins of the tile.
- Provides start/busy/done handshaking and an abort.

Parameters:
- WIDTH, 8, resolution in bits, legal range 2..12.
- SAMPLE_CYCLES, 2, number of clocks the sample output is held high, at least 1.
- SETTLE_CYCLES, 4, clocks each trial code is held before the comparator is read; must be greater than SYNC_STAGES.
- SYNC_STAGES, 2, flops in the cmp_in synchronizer, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request, level-sampled, honoured only in IDLE.
- abort  in  1  cancels an in-flight conversion.
- cmp_in  in  1  asynchronous comparator output; 1 means Vin is at or above the DAC level.
- sample  out  1  track/hold enable, high while tracking.
- dac_code  out  WIDTH  trial code to the DAC.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  last completed conversion.
- valid  out  1  result holds a completed conversion not yet superseded.

Behaviour:
- Reset (rst=1 at a clk edge) forces, on that edge:
  - state IDLE;
  - sample, busy, done and valid to 0;
  - dac_code and result to 0;
  - synchronizer flops to 0.
- Reset has priority over everything, including mid-conversion.
- cmp_in passes through a SYNC_STAGES flop chain; only the synchronized value (cmp_s) is used.
- FSM states: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - dac_code=0 and sample=0.
  - If start=1 at edge k: go to SAMPLE, busy=1, valid=0, sample cycle counter=0.
- SAMPLE:
  - sample=1 for exactly SAMPLE_CYCLES cycles.
  - On the last cycle, load bit index=WIDTH-1 and dac_code = 1<<(WIDTH-1), then go to CONV.
- CONV:
  - Each bit window is SETTLE_CYCLES cycles with dac_code held constant.
  - On the edge ending a window, read cmp_s. If cmp_s=0, clear the current trial bit; if 1, keep it.
  - If the index is above 0, set the next lower bit and decrement the index.
  - If the index is 0, copy the final code to result and go to DONE.
  - dac_code never changes inside a window.
- DONE (one cycle):
  - done=1, valid=1, busy=0 (busy drops in the same cycle done rises), dac_code holds the final code.
  - Next state is IDLE, where dac_code returns to 0.
- Latency: start sampled at edge k, then done is high in the cycle after edge k+SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES.
  - Defaults: done in cycle k+35 relative edges.
- start while busy: ignored, no queuing.
- start=1 held continuously: a new conversion is accepted in the IDLE cycle after DONE, so there is exactly one IDLE cycle between conversions.
- abort=1 in SAMPLE or CONV:
  - next state IDLE; sample, busy and dac_code go to 0;
  - no done pulse; result is unchanged; valid stays 0.
- abort in IDLE or DONE: no effect.
- abort and start together in IDLE: start wins, because abort applies only when busy.
- result is stable except on the DONE transition edge.
- valid clears only on start acceptance or reset.
- Counters are sized for the parameter maxima; there is no wrap inside a conversion.

Test Plan:
- Reset mid-CONV with WIDTH=8: assert rst for one edge during bit 5 -> next cycle every output is 0 and state is IDLE; a following start with Vin=0x3C gives result=0x3C.
- Basic conversion, defaults, comparator model cmp=(Vin>=dac_code) with Vin=0xA5:
  - dac_code sequence per window is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5;
  - done pulses exactly once, 35 cycles after the start edge;
  - result=0xA5, valid=1.
- Endpoints: Vin=0x00 gives result 0x00; Vin=0xFF gives result 0xFF with every trial kept; busy high for exactly 34 cycles in each case.
- Handshake: pulse start again at cycle k+10 -> ignored, a single done, result unchanged. Hold start high -> back-to-back conversions with a single-cycle IDLE gap, valid dropping for the second.
- Abort: abort at cycle k+12 -> the next cycle has busy=0, sample=0 and dac_code=0; no done; result keeps its prior value 0xA5; valid=0.
- Synchronizer/settle: glitch cmp_in for 1 cycle early in a window, cleared before SYNC_STAGES cycles ahead of the window end -> the decision uses the settled value and the result is unaffected.
